// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin sequencer sharing one multi-cycle RAM between two ports
//
// Purpose: arbitrates a read-only fetch port (A) and a read/write data port (B)
// onto a single RAM with an en/we/addr/wdata request and a one-cycle finish
// pulse. One access is outstanding at a time. A watchdog aborts accesses that
// never finish.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   req_a, addr_a     port A read request and address (held until ack_a)
//   ack_a, rdata_a    port A one-cycle completion pulse and read data
//   req_b, we_b,      port B request, write enable, address and write data
//   addr_b, wdata_b   (held until ack_b)
//   ack_b, rdata_b    port B one-cycle completion pulse and read data
//   resp_err          high alongside ack_x when that access timed out
//   err_sticky        set on any timeout, cleared only by reset
//   mem_en, mem_we,   RAM request, held stable for the whole access
//   mem_addr,
//   mem_wdata
//   mem_rdata,        RAM read data and completion pulse
//   mem_finish
module ram_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] addr_a,
  output logic        ack_a,
  output logic [31:0] rdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_b,
  output logic [31:0] rdata_b,
  output logic        resp_err,
  output logic        err_sticky,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_finish
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_last_b;     // 1 when port B won the most recent grant
  logic             r_sel_b;      // port owning the current access
  logic             r_ack_a;
  logic             r_ack_b;
  logic             r_resp_err;
  logic             r_err_sticky;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_rdata_a;
  logic [31:0]      r_rdata_b;
  logic [CNT_W-1:0] r_cnt;

  logic w_grant_b;
  logic w_timeout;

  // B wins when it is the only requester, or on a tie when A won last time.
  assign w_grant_b = req_b & (~req_a | r_last_b == 1'b0);
  assign w_timeout = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_b     <= 1'b1;
      r_sel_b      <= 1'b0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_resp_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
      r_cnt        <= '0;
    end else begin
      // ack and resp_err are single-cycle pulses raised only on entry to RESP.
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_resp_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_a || req_b) begin
            r_sel_b     <= w_grant_b;
            r_last_b    <= w_grant_b;
            r_mem_we    <= w_grant_b & we_b;
            r_mem_addr  <= w_grant_b ? addr_b : addr_a;
            r_mem_wdata <= w_grant_b ? wdata_b : '0;
            r_mem_en    <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // finish takes priority over a timeout landing in the same cycle
          if (mem_finish) begin
            if (!r_mem_we) begin
              if (r_sel_b) begin
                r_rdata_b <= mem_rdata;
              end else begin
                r_rdata_a <= mem_rdata;
              end
            end
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_ack_a  <= ~r_sel_b;
            r_ack_b  <= r_sel_b;
            r_state  <= S_RESP;
          end else if (w_timeout) begin
            r_err_sticky <= 1'b1;
            r_resp_err   <= 1'b1;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_ack_a      <= ~r_sel_b;
            r_ack_b      <= r_sel_b;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign rdata_a    = r_rdata_a;
  assign rdata_b    = r_rdata_b;
  assign resp_err   = r_resp_err;
  assign err_sticky = r_err_sticky;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
